e_mdu: RTL and testbench

Execute-stage multiply/divide unit for the pipelined MIPS core; it sits beside the ALU and feeds the E→M pipeline register. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO in E and models multi-cycle latency with a busy counter. It holds the architectural HI/LO registers, whose values the E stage forwards for MFHI/MFLO. The hazard unit uses `start | busy` to stall D when an MDU instruction is decoded.

---
 rtl/e_mdu.sv | 133 +++++++++++++
 tb/tb_e_mdu.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: holds HI/LO and models multi-cycle
// MULT/DIV latency with a busy down-counter; MTHI/MTLO write in one cycle.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdu_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [2:0] {
    OP_NONE, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO, OP_RSVD
  } op_t;

  typedef enum logic { IDLE, RUN } state_t;

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic [31:0] hi_tmp, hi_tmp_nx, lo_tmp, lo_tmp_nx, hi_nx, lo_nx;
  logic        dz, dz_nx;

  logic [63:0] prod_s, prod_u;
  logic [31:0] a_mag, b_mag, b_mag_safe, b_safe, q_mag, r_mag;
  logic [31:0] quo_s, rem_s, quo_u, rem_u;

  assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign prod_u = {32'b0, A} * {32'b0, B};

  // Signed divide on magnitudes: keeps 0x80000000 / -1 well defined (wraps).
  assign a_mag      = A[31] ? -A : A;
  assign b_mag      = B[31] ? -B : B;
  assign b_mag_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign q_mag      = a_mag / b_mag_safe;
  assign r_mag      = a_mag % b_mag_safe;
  assign quo_s      = (A[31] ^ B[31]) ? -q_mag : q_mag;
  assign rem_s      = A[31] ? -r_mag : r_mag;
  assign b_safe     = (B == 32'd0) ? 32'd1 : B;
  assign quo_u      = A / b_safe;
  assign rem_u      = A % b_safe;

  assign busy = (state == RUN);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    state_nx  = state;
    cnt_nx    = cnt;
    hi_nx     = HI;
    lo_nx     = LO;
    hi_tmp_nx = hi_tmp;
    lo_tmp_nx = lo_tmp;
    dz_nx     = dz;
    case (state)
      IDLE: begin
        if (start) begin
          case (op_t'(mdu_op))
            OP_MULT: begin
              {hi_tmp_nx, lo_tmp_nx} = prod_s;
              dz_nx    = 1'b0;
              cnt_nx   = MULT_CNT;
              state_nx = RUN;
            end
            OP_MULTU: begin
              {hi_tmp_nx, lo_tmp_nx} = prod_u;
              dz_nx    = 1'b0;
              cnt_nx   = MULT_CNT;
              state_nx = RUN;
            end
            OP_DIV: begin
              hi_tmp_nx = rem_s;
              lo_tmp_nx = quo_s;
              dz_nx     = (B == 32'd0);
              cnt_nx    = DIV_CNT;
              state_nx  = RUN;
            end
            OP_DIVU: begin
              hi_tmp_nx = rem_u;
              lo_tmp_nx = quo_u;
              dz_nx     = (B == 32'd0);
              cnt_nx    = DIV_CNT;
              state_nx  = RUN;
            end
            OP_MTHI: hi_nx = A;
            OP_MTLO: lo_nx = A;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_nx = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_nx = IDLE;
          if (!dz) begin
            hi_nx = hi_tmp;
            lo_nx = lo_tmp;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      HI     <= 32'd0;
      LO     <= 32'd0;
      hi_tmp <= 32'd0;
      lo_tmp <= 32'd0;
      dz     <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      HI     <= hi_nx;
      LO     <= lo_nx;
      hi_tmp <= hi_tmp_nx;
      lo_tmp <= lo_tmp_nx;
      dz     <= dz_nx;
    end
  end

endmodule

// File: tb/tb_e_mdu.sv
// Scoreboard bench for e_mdu: the driver pushes expected commits from an
// arithmetic reference model, a monitor pops them when busy falls.
module tb_e_mdu;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  mdu_op;
  logic [31:0] A, B;
  logic        busy;
  logic [31:0] HI, LO;

  e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .mdu_op(mdu_op),
    .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO)
  );

  typedef struct {
    int          len;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_hi, m_lo;
  int          checks = 0;
  int          errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: samples just after each rising edge.
  initial begin
    int   run_len;
    logic prev_busy;
    exp_t e;
    run_len   = 0;
    prev_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        run_len   = 0;
        prev_busy = 1'b0;
      end else begin
        if (busy) run_len++;
        else if (prev_busy) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_commit actual=HI %h LO %h expected=no commit", HI, LO);
          end else begin
            e = sb.pop_front();
            check("busy_len", 32'(run_len), 32'(e.len));
            check("commit_hi", HI, e.hi);
            check("commit_lo", LO, e.lo);
          end
          run_len = 0;
        end
        prev_busy = busy;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout actual=busy %b expected=0", busy);
    end
  endtask

  // Drives one op at a negedge in the first idle cycle; returns at the next negedge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t            e;
    longint          p, q, r;
    longint unsigned pu;
    wait_idle();
    start  = 1'b1;
    mdu_op = op;
    A      = a;
    B      = b;
    e.len  = 0;
    case (op)
      3'd1: begin
        p = longint'($signed(a)) * longint'($signed(b));
        m_hi = p[63:32]; m_lo = p[31:0]; e.len = MC;
      end
      3'd2: begin
        pu = longint'(a) * longint'(b);
        m_hi = pu[63:32]; m_lo = pu[31:0]; e.len = MC;
      end
      3'd3: begin
        if (b != 0) begin
          q = longint'($signed(a)) / longint'($signed(b));
          r = longint'($signed(a)) % longint'($signed(b));
          m_lo = q[31:0]; m_hi = r[31:0];
        end
        e.len = DC;
      end
      3'd4: begin
        if (b != 0) begin
          m_lo = a / b; m_hi = a % b;
        end
        e.len = DC;
      end
      3'd5: m_hi = a;
      3'd6: m_lo = a;
      default: ;
    endcase
    if (e.len != 0) begin
      e.hi = m_hi;
      e.lo = m_lo;
      sb.push_back(e);
    end
    @(negedge clk);
    start  = 1'b0;
    mdu_op = 3'($urandom);
    A      = $urandom;
    B      = $urandom;
    if (e.len == 0) begin
      check("single_cycle_busy", 32'(busy), 32'd0);
      check("single_cycle_hi", HI, m_hi);
      check("single_cycle_lo", LO, m_lo);
    end
  endtask

  // One-cycle start pulse while RUN; must be ignored.
  task automatic poke_mid_run(input logic [2:0] op);
    @(negedge clk);
    start  = 1'b1;
    mdu_op = op;
    A      = $urandom;
    B      = $urandom;
    @(negedge clk);
    start  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    int          n;

    reset = 1'b1; start = 1'b0; mdu_op = 3'd0; A = '0; B = '0;
    m_hi = '0; m_lo = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_hi", HI, 32'd0);
    check("reset_lo", LO, 32'd0);

    issue(3'd1, 32'hFFFF_FFFF, 32'd2);
    wait_idle();
    check("mult_hi", HI, 32'hFFFF_FFFF);
    check("mult_lo", LO, 32'hFFFF_FFFE);

    issue(3'd2, 32'hFFFF_FFFF, 32'd2);
    wait_idle();
    check("multu_hi", HI, 32'h0000_0001);
    check("multu_lo", LO, 32'hFFFF_FFFE);

    issue(3'd3, 32'hFFFF_FFF9, 32'd2);
    wait_idle();
    check("div_hi", HI, 32'hFFFF_FFFF);
    check("div_lo", LO, 32'hFFFF_FFFD);

    issue(3'd5, 32'h1234_5678, 32'd0);
    issue(3'd6, 32'h9ABC_DEF0, 32'd0);
    issue(3'd4, 32'd7, 32'd0);
    wait_idle();
    check("dz_hi", HI, 32'h1234_5678);
    check("dz_lo", LO, 32'h9ABC_DEF0);

    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle();
    check("ovf_hi", HI, 32'd0);
    check("ovf_lo", LO, 32'h8000_0000);

    // Reset during busy cycle 3 discards the pending result.
    issue(3'd1, 32'd1234, 32'd5678);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    sb.delete();
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    reset = 1'b0;
    check("rst_run_busy", 32'(busy), 32'd0);
    check("rst_run_hi", HI, 32'd0);
    check("rst_run_lo", LO, 32'd0);
    repeat (12) @(negedge clk);
    check("rst_no_commit_hi", HI, 32'd0);
    check("rst_no_commit_lo", LO, 32'd0);

    issue(3'd1, 32'hDEAD_BEEF, 32'h0000_0100);
    poke_mid_run(3'd6);
    poke_mid_run(3'd5);
    wait_idle();

    issue(3'd4, 32'd100, 32'd7);
    issue(3'd2, 32'd3, 32'd4);
    wait_idle();
    check("b2b_hi", HI, 32'd0);
    check("b2b_lo", LO, 32'd12);

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      n  = $urandom_range(0, 9);
      if (n == 0) b = 32'd0;
      else if (n == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (n == 2) b = 32'($urandom_range(1, 9));
      issue(op, a, b);
      if ((op >= 3'd1 && op <= 3'd4) && $urandom_range(0, 1) == 1)
        poke_mid_run(3'($urandom_range(0, 7)));
    end

    wait_idle();
    @(negedge clk);
    check("final_hi", HI, m_hi);
    check("final_lo", LO, m_lo);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
